// File: rtl/train_sequencer_if.sv
// train_sequencer_if
//   Bundles the load, run-control, network-handshake and sample-output
//   signals of train_sequencer. Clock and reset stay outside as plain ports.
//
//   Signals (direction seen from the sequencer, the slave side):
//     load_valid_i / load_data_i / load_ready_o : sample write handshake
//     clear_i, start_i, abort_i, epochs_i       : run control
//     net_done_i                                 : per-sample completion
//     x_o, target_o, init_o                      : sample presented to the network
//     busy_o, done_o, epoch_o, sample_idx_o      : run status
//
//   master : the block driving samples/control (testbench or host)
//   slave  : train_sequencer
interface train_sequencer_if #(
  parameter int DEPTH   = 4,
  parameter int EPOCH_W = 8
);
  localparam int IDX_W = $clog2(DEPTH);

  logic               load_valid_i;
  logic [7:0]         load_data_i;
  logic               load_ready_o;
  logic               clear_i;
  logic               start_i;
  logic               abort_i;
  logic [EPOCH_W-1:0] epochs_i;
  logic               net_done_i;
  logic [3:0]         x_o;
  logic [3:0]         target_o;
  logic               init_o;
  logic               busy_o;
  logic               done_o;
  logic [EPOCH_W-1:0] epoch_o;
  logic [IDX_W-1:0]   sample_idx_o;

  modport master (
    output load_valid_i, load_data_i, clear_i, start_i, abort_i, epochs_i, net_done_i,
    input  load_ready_o, x_o, target_o, init_o, busy_o, done_o, epoch_o, sample_idx_o
  );

  modport slave (
    input  load_valid_i, load_data_i, clear_i, start_i, abort_i, epochs_i, net_done_i,
    output load_ready_o, x_o, target_o, init_o, busy_o, done_o, epoch_o, sample_idx_o
  );
endinterface

// File: rtl/train_sequencer.sv
// train_sequencer
//   Buffers up to DEPTH training samples ({target[3:0], x[3:0]}) and replays
//   them one per network iteration: each sample is presented on x_o/target_o
//   together with a one-cycle init_o pulse, then held until net_done_i. The
//   whole set is repeated for the number of epochs latched at start, after
//   which done_o is raised.
//
//   Ports:
//     clk_i  : clock
//     rst_i  : synchronous, active-low reset (discards run and buffer)
//     bus    : train_sequencer_if.slave (load handshake, run control,
//              network handshake, sample outputs and status)
//
//   Optional feature: define SHUFFLE_EN to rotate the presentation order by
//   one slot per epoch, ord(i) = (i + epoch[IDX_W-1:0]) mod cnt. Without it
//   samples are always presented in load order.
module train_sequencer #(
  parameter int DEPTH   = 4,
  parameter int EPOCH_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  train_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   i, i_nxt, ord_nxt;
  logic [EPOCH_W-1:0] epoch, epoch_nxt, e_lat, e_nxt;
  logic [3:0]         x_val, target_val;
  logic [IDX_W-1:0]   idx_val;
  logic               init_pulse, issue, wr_en, load_ready;
  logic               last_sample, last_epoch;

  // Epoch counter never passes the programmed count, even at E = 2^EPOCH_W-1.
  function automatic logic [EPOCH_W-1:0] sat_inc(input logic [EPOCH_W-1:0] v,
                                                 input logic [EPOCH_W-1:0] lim);
    return (v >= lim) ? lim : v + EPOCH_W'(1);
  endfunction

`ifdef SHUFFLE_EN
  function automatic logic [IDX_W-1:0] rotate(input logic [IDX_W-1:0] idx,
                                              input logic [IDX_W-1:0] rot,
                                              input logic [CNT_W-1:0] n);
    logic [CNT_W-1:0] sum;
    sum = CNT_W'(idx) + CNT_W'(rot);
    if (n == '0) return '0;
    return IDX_W'(sum % n);
  endfunction

  assign ord_nxt = rotate(i_nxt, epoch_nxt[IDX_W-1:0], cnt);
`else
  assign ord_nxt = i_nxt;
`endif

  assign load_ready  = (state == IDLE) && (cnt < CNT_W'(DEPTH));
  assign wr_en       = bus.load_valid_i && load_ready && !bus.clear_i && !bus.abort_i;
  assign last_sample = (CNT_W'(i) + CNT_W'(1)) == cnt;
  // Compared one bit wider so E = all-ones cannot wrap.
  assign last_epoch  = ((EPOCH_W+1)'(epoch) + (EPOCH_W+1)'(1)) == (EPOCH_W+1)'(e_lat);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    i_nxt     = i;
    epoch_nxt = epoch;
    e_nxt     = e_lat;
    issue     = 1'b0;
    if (wr_en) cnt_nxt = cnt + CNT_W'(1);
    if (bus.abort_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.clear_i) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else if (bus.start_i && (cnt != '0) && (bus.epochs_i != '0)) begin
            e_nxt     = bus.epochs_i;
            epoch_nxt = '0;
            i_nxt     = '0;
            state_nxt = ISSUE;
            issue     = 1'b1;
          end
        end
        ISSUE: state_nxt = WAIT;
        WAIT:  if (bus.net_done_i) state_nxt = NEXT;
        NEXT: begin
          if (last_sample) begin
            i_nxt     = '0;
            epoch_nxt = sat_inc(epoch, e_lat);
            if (last_epoch) begin
              state_nxt = DONE;
            end else begin
              state_nxt = ISSUE;
              issue     = 1'b1;
            end
          end else begin
            i_nxt     = i + IDX_W'(1);
            state_nxt = ISSUE;
            issue     = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Sample outputs and init_o are loaded on the edge that enters ISSUE, so
  // they are valid in the same cycle the state machine sees init.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      i          <= '0;
      epoch      <= '0;
      e_lat      <= '0;
      init_pulse <= 1'b0;
      x_val      <= '0;
      target_val <= '0;
      idx_val    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      i          <= i_nxt;
      epoch      <= epoch_nxt;
      e_lat      <= e_nxt;
      init_pulse <= issue;
      if (bus.abort_i) begin
        x_val      <= '0;
        target_val <= '0;
      end else if (issue) begin
        x_val      <= mem[ord_nxt][3:0];
        target_val <= mem[ord_nxt][7:4];
        idx_val    <= ord_nxt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[cnt[IDX_W-1:0]] <= bus.load_data_i;
  end

  assign bus.load_ready_o = load_ready;
  assign bus.busy_o       = (state == ISSUE) || (state == WAIT) || (state == NEXT);
  assign bus.done_o       = (state == DONE);
  assign bus.init_o       = init_pulse;
  assign bus.x_o          = x_val;
  assign bus.target_o     = target_val;
  assign bus.epoch_o      = epoch;
  assign bus.sample_idx_o = idx_val;
endmodule
